// File: rtl/chain_mon_pkg.sv
// Shared types, defaults and helper functions for the chain settle monitor.
package chain_mon_pkg;

  localparam int DEF_STAGES  = 5;
  localparam int DEF_W       = 3;
  localparam int DEF_SEED    = 1;
  localparam int DEF_TIMEOUT = 15;

  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    SETTLED = 2'd2,
    FAIL    = 2'd3
  } state_t;

  // Value tap i must hold once the chain has fully propagated; wraps mod 2^w.
  function automatic int expected_tap(input int seed, input int i, input int w);
    return (seed + i) % (1 << w);
  endfunction

  // Index of the lowest zero bit among the first n bits of vec (0 if none).
  function automatic int lowest_zero(input logic [31:0] vec, input int n);
    int idx;
    idx = 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (!vec[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/chain_tap_compare.sv
// Combinational comparison of each chain tap against its elaborated constant,
// plus the prefix-AND lock vector (tap i and every tap below it match).
module chain_tap_compare
  import chain_mon_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int W      = DEF_W,
  parameter int SEED   = DEF_SEED
) (
  input  logic [STAGES*W-1:0] taps,
  output logic [STAGES-1:0]   match,
  output logic [STAGES-1:0]   lock
);

  for (genvar i = 0; i < STAGES; i++) begin : g_tap
    localparam logic [W-1:0] EXP = W'(expected_tap(SEED, i, W));
    assign match[i] = (taps[i*W +: W] == EXP);
  end

  // Running AND from tap 0 upward gives the lock prefix.
  always_comb begin
    logic run;
    run  = 1'b1;
    lock = '0;
    for (int i = 0; i < STAGES; i++) begin
      run     = run & match[i];
      lock[i] = run;
    end
  end

endmodule

// File: rtl/chain_settle_monitor.sv
// Passive monitor: measures chain settle time after arm, flags out-of-order
// settling, then watches the settled chain for corruption.
module chain_settle_monitor
  import chain_mon_pkg::*;
#(
  parameter int STAGES  = DEF_STAGES,
  parameter int W       = DEF_W,
  parameter int SEED    = DEF_SEED,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int MS_W   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic [STAGES*W-1:0] taps,
  output logic                busy,
  output logic                settled,
  output logic                fail,
  output logic [CNT_W-1:0]    settle_cycles,
  output logic [MS_W-1:0]     mismatch_stage,
  output logic                order_viol
);

  logic [STAGES-1:0] match;
  logic [STAGES-1:0] lock;

  chain_tap_compare #(
    .STAGES (STAGES),
    .W      (W),
    .SEED   (SEED)
  ) u_cmp (
    .taps  (taps),
    .match (match),
    .lock  (lock)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              ov_q, ov_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [MS_W-1:0]   first_bad;

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
  assign first_bad = MS_W'(lowest_zero(32'(match), STAGES));

  // Next-state and field updates for the monitor FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    ms_d    = ms_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WATCH;
          cnt_d   = '0;
          ms_d    = '0;
          ov_d    = 1'b0;
        end
      end
      WATCH: begin
        cnt_d = cnt_inc;
        if (|(match & ~lock)) ov_d = 1'b1;
        if (&match) begin
          state_d = SETTLED;
        end else if (cnt_inc >= 8'(TIMEOUT)) begin
          state_d = FAIL;
          ms_d    = first_bad;
        end
      end
      SETTLED: begin
        if (arm) begin
          state_d = WATCH;
          cnt_d   = '0;
          ms_d    = '0;
          ov_d    = 1'b0;
        end else if (!(&match)) begin
          state_d = FAIL;
          ms_d    = first_bad;
        end
      end
      FAIL: begin
        if (arm) begin
          state_d = WATCH;
          cnt_d   = '0;
          ms_d    = '0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and field registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ms_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ms_q    <= ms_d;
      ov_q    <= ov_d;
    end
  end

  // Status outputs decode directly from registered state; no input reaches them combinationally.
  assign busy           = (state_q == WATCH);
  assign settled        = (state_q == SETTLED);
  assign fail           = (state_q == FAIL);
  assign settle_cycles  = cnt_q;
  assign mismatch_stage = ms_q;
  assign order_viol     = ov_q;

endmodule

// File: tb/tb_chain_settle_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the monitor.
module tb_chain_settle_monitor;

  localparam int STAGES  = 5;
  localparam int W       = 3;
  localparam int SEED    = 1;
  localparam int TIMEOUT = 15;
  localparam int MS_W    = 3;

  logic                clk;
  logic                rst;
  logic                arm;
  logic [STAGES*W-1:0] taps;
  logic                busy;
  logic                settled;
  logic                fail;
  logic [7:0]          settle_cycles;
  logic [MS_W-1:0]     mismatch_stage;
  logic                order_viol;

  int checks;
  int errors;

  chain_settle_monitor #(
    .STAGES  (STAGES),
    .W       (W),
    .SEED    (SEED),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arm            (arm),
    .taps           (taps),
    .busy           (busy),
    .settled        (settled),
    .fail           (fail),
    .settle_cycles  (settle_cycles),
    .mismatch_stage (mismatch_stage),
    .order_viol     (order_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 watching, 2 settled, 3 failed.
  int m_phase;
  int m_cnt;
  int m_ms;
  int m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [STAGES*W-1:0] pack5(input int t0, input int t1, input int t2,
                                                input int t3, input int t4);
    return {W'(t4), W'(t3), W'(t2), W'(t1), W'(t0)};
  endfunction

  // Lowest tap index that does not hold its settled value, or -1 if all do.
  function automatic int first_wrong(input logic [STAGES*W-1:0] t);
    for (int i = 0; i < STAGES; i++) begin
      if (int'(t[i*W +: W]) != (SEED + i) % (1 << W)) return i;
    end
    return -1;
  endfunction

  // True when some tap holds its settled value while a lower tap does not.
  function automatic bit out_of_order(input logic [STAGES*W-1:0] t);
    int fw;
    fw = first_wrong(t);
    if (fw < 0) return 1'b0;
    for (int i = fw + 1; i < STAGES; i++) begin
      if (int'(t[i*W +: W]) == (SEED + i) % (1 << W)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_restart();
    m_phase = 1; m_cnt = 0; m_ms = 0; m_ov = 0;
  endtask

  task automatic model_update(input logic r, input logic a, input logic [STAGES*W-1:0] t);
    int fw;
    fw = first_wrong(t);
    if (r) begin
      m_phase = 0; m_cnt = 0; m_ms = 0; m_ov = 0;
    end else begin
      case (m_phase)
        0: if (a) model_restart();
        1: begin
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (out_of_order(t)) m_ov = 1;
          if (fw < 0) m_phase = 2;
          else if (m_cnt >= TIMEOUT) begin
            m_phase = 3;
            m_ms    = fw;
          end
        end
        2: begin
          if (a) model_restart();
          else if (fw >= 0) begin
            m_phase = 3;
            m_ms    = fw;
          end
        end
        default: if (a) model_restart();
      endcase
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after it.
  task automatic cycle(input logic r, input logic a, input logic [STAGES*W-1:0] t);
    rst  = r;
    arm  = a;
    taps = t;
    @(posedge clk);
    model_update(r, a, t);
    #1;
    check("busy",           busy,           m_phase == 1);
    check("settled",        settled,        m_phase == 2);
    check("fail",           fail,           m_phase == 3);
    check("settle_cycles",  settle_cycles,  m_cnt);
    check("mismatch_stage", mismatch_stage, m_ms);
    check("order_viol",     order_viol,     m_ov);
  endtask

  logic [STAGES*W-1:0] good;
  logic [STAGES*W-1:0] zeros;
  logic [STAGES*W-1:0] rt;

  initial begin
    checks = 0;
    errors = 0;
    m_phase = 0; m_cnt = 0; m_ms = 0; m_ov = 0;
    good  = pack5(1, 2, 3, 4, 5);
    zeros = '0;
    rst = 1'b1; arm = 1'b0; taps = '0;
    #2;

    // 1: reset with arbitrary taps, then idle
    cycle(1'b1, 1'b0, pack5(7, 3, 0, 6, 2));
    cycle(1'b1, 1'b1, pack5(1, 5, 4, 0, 7));
    check("rst_busy",    busy,          0);
    check("rst_cycles",  settle_cycles, 0);
    check("rst_ov",      order_viol,    0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 15'($urandom));
    check("idle_busy",   busy,    0);
    check("idle_settled", settled, 0);

    // 2: staged propagation
    cycle(1'b0, 1'b1, zeros);
    cycle(1'b0, 1'b0, pack5(1, 1, 1, 1, 1));
    cycle(1'b0, 1'b0, pack5(1, 2, 2, 2, 2));
    cycle(1'b0, 1'b0, pack5(1, 2, 3, 3, 3));
    cycle(1'b0, 1'b0, pack5(1, 2, 3, 4, 4));
    cycle(1'b0, 1'b0, good);
    check("prop_settled", settled,       1);
    check("prop_cycles",  settle_cycles, 5);
    check("prop_ov",      order_viol,    0);

    // 3: all at once
    cycle(1'b0, 1'b1, good);
    cycle(1'b0, 1'b0, good);
    check("once_settled", settled,       1);
    check("once_cycles",  settle_cycles, 1);

    // 4: corruption after settle, then re-arm
    cycle(1'b0, 1'b0, pack5(1, 2, 7, 4, 5));
    check("corrupt_fail", fail,           1);
    check("corrupt_ms",   mismatch_stage, 2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, good);
    check("fail_sticky",  fail,           1);
    cycle(1'b0, 1'b1, good);
    cycle(1'b0, 1'b0, good);
    check("rearm_settled", settled,       1);
    check("rearm_cycles",  settle_cycles, 1);
    check("rearm_fail",    fail,          0);

    // 5a: timeout with all taps wrong
    cycle(1'b0, 1'b1, zeros);
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 1'b0, zeros);
    check("to_fail",   fail,           1);
    check("to_cycles", settle_cycles,  15);
    check("to_ms",     mismatch_stage, 0);

    // 5b: out-of-order tap on first sample
    cycle(1'b0, 1'b1, zeros);
    cycle(1'b0, 1'b0, pack5(0, 0, 3, 0, 0));
    check("ooo_flag", order_viol, 1);
    for (int i = 1; i < TIMEOUT; i++) cycle(1'b0, 1'b0, zeros);
    check("ooo_fail", fail,       1);
    check("ooo_keep", order_viol, 1);

    // 6: reset mid-watch with a simultaneous arm
    cycle(1'b0, 1'b1, zeros);
    cycle(1'b0, 1'b0, pack5(1, 1, 1, 1, 1));
    cycle(1'b0, 1'b0, pack5(1, 1, 1, 1, 1));
    cycle(1'b1, 1'b1, pack5(1, 1, 1, 1, 1));
    check("midrst_busy",   busy,          0);
    check("midrst_cycles", settle_cycles, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, good);
    check("midrst_idle", busy, 0);

    // Randomized traffic: taps mostly correct, occasional arm and reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < STAGES; i++) begin
        if ($urandom_range(0, 3) != 0) rt[i*W +: W] = W'((SEED + i) % (1 << W));
        else                           rt[i*W +: W] = W'($urandom);
      end
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
